// File: rtl/branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// branch_redirect_unit
//
// Execute-side control-transfer resolver. It accepts one branch/jal/jalr from
// decode and spends one cycle resolving the condition and the 32-bit target.
// A taken, aligned transfer is then offered to fetch as a held valid/ready
// redirect. Once fetch accepts it, a flush of fixed length kills the younger
// instructions in IF/ID.
//
// Parameters
//   FLUSH_CYCLES : cycles flush stays high after the redirect handshake (1..15)
//   CNT_W        : width of the branch / taken statistic counters
//
// Ports
//   clk, rst            : core clock; asynchronous active-high reset
//   in_valid / in_ready : decode -> unit instruction handshake
//   pc, branoff         : instruction PC and 12-bit decoder offset
//   jal, jalr           : transfer kind (jal has priority when both are set)
//   funct3              : branch condition select
//   rs1_mod, rs2_mod    : forwarded operands
//   redir_valid/ready   : redirect handshake to fetch, target on redir_pc
//   flush               : kill younger instructions in IF/ID
//   link_valid/data     : one-cycle link pulse, pc+4 held until the next link
//   misalign            : one-cycle pulse, taken target has bit1 set
//   branch_cnt          : resolved control transfers (wraps)
//   taken_cnt           : redirected control transfers (wraps)
// -----------------------------------------------------------------------------
module branch_redirect_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      pc,
    input  logic [11:0]      branoff,
    input  logic             jal,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic [31:0]      rs1_mod,
    input  logic [31:0]      rs2_mod,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [31:0]      link_data,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_REDIRECT,
        ST_FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;

    logic [31:0]        pc_q, pc_d;
    logic [11:0]        off_q, off_d;
    logic               jal_q, jal_d;
    logic               jalr_q, jalr_d;     // already masked by jal priority
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;

    logic               redir_valid_q, redir_valid_d;
    logic [31:0]        redir_pc_q, redir_pc_d;
    logic               flush_q, flush_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic               link_valid_q, link_valid_d;
    logic [31:0]        link_data_q, link_data_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

    // -------------------------------------------------------------------------
    // Resolve datapath (only meaningful while in ST_RESOLVE)
    // -------------------------------------------------------------------------
    logic        cond_taken;
    logic        is_link;
    logic        taken;
    logic [31:0] target_rel;
    logic [31:0] target_jalr;
    logic [31:0] target;

    always_comb begin
        cond_taken = 1'b0;
        case (f3_q)
            3'b000:  cond_taken = (rs1_q == rs2_q);
            3'b001:  cond_taken = (rs1_q != rs2_q);
            3'b100:  cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cond_taken = (rs1_q <  rs2_q);
            3'b111:  cond_taken = (rs1_q >= rs2_q);
            default: cond_taken = 1'b0;     // 010/011 are not branches
        endcase
    end

    assign is_link     = jal_q | jalr_q;
    assign taken       = is_link | cond_taken;
    assign target_rel  = pc_q + {{20{off_q[11]}}, off_q};
    // For jalr the decoder already folded rs1+imm into the offset; only the
    // page bits come from the PC and bit0 is cleared.
    assign target_jalr = {pc_q[31:12], off_q[11:1], 1'b0};
    assign target      = jalr_q ? target_jalr : target_rel;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves a
    // combinational output unassigned (which would infer a latch).
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        off_d         = off_q;
        jal_d         = jal_q;
        jalr_d        = jalr_q;
        f3_d          = f3_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = flush_q;
        flush_cnt_d   = flush_cnt_q;
        link_valid_d  = 1'b0;               // pulse outputs
        link_data_d   = link_data_q;
        misalign_d    = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        taken_cnt_d   = taken_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pc_d    = pc;
                    off_d   = branoff;
                    jal_d   = jal;
                    jalr_d  = jalr & ~jal;
                    f3_d    = funct3;
                    rs1_d   = rs1_mod;
                    rs2_d   = rs2_mod;
                    state_d = ST_RESOLVE;
                end
            end

            ST_RESOLVE: begin
                branch_cnt_d = branch_cnt_q + 1'b1;
                if (is_link) begin
                    link_valid_d = 1'b1;
                    link_data_d  = pc_q + 32'd4;
                end
                state_d = ST_IDLE;
                if (taken) begin
                    if (target[1]) begin
                        misalign_d = 1'b1;
                    end else begin
                        taken_cnt_d   = taken_cnt_q + 1'b1;
                        redir_pc_d    = target;
                        redir_valid_d = 1'b1;
                        state_d       = ST_REDIRECT;
                    end
                end
            end

            ST_REDIRECT: begin
                if (redir_ready) begin
                    redir_valid_d = 1'b0;
                    flush_d       = 1'b1;
                    flush_cnt_d   = FLUSH_LOAD;
                    state_d       = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // The counter holds the flush-high cycles still to run,
                // including the current one.
                if (flush_cnt_q <= 4'd1) begin
                    flush_d     = 1'b0;
                    flush_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. All registers
    // are small flops (no memories), so all of them are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            off_q         <= '0;
            jal_q         <= 1'b0;
            jalr_q        <= 1'b0;
            f3_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            flush_cnt_q   <= '0;
            link_valid_q  <= 1'b0;
            link_data_q   <= '0;
            misalign_q    <= 1'b0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            off_q         <= off_d;
            jal_q         <= jal_d;
            jalr_q        <= jalr_d;
            f3_q          <= f3_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            flush_cnt_q   <= flush_cnt_d;
            link_valid_q  <= link_valid_d;
            link_data_q   <= link_data_d;
            misalign_q    <= misalign_d;
            branch_cnt_q  <= branch_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = (state_q == ST_IDLE);
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush       = flush_q;
    assign link_valid  = link_valid_q;
    assign link_data   = link_data_q;
    assign misalign    = misalign_q;
    assign branch_cnt  = branch_cnt_q;
    assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_unit
//
// Directed plus randomized bench for branch_redirect_unit. Expected results
// come from a behavioural model of the transfer rules (condition, target,
// alignment, counters, link value). The counter width is reduced so that the
// wrap-around can be reached in a short run.
// -----------------------------------------------------------------------------
module tb_branch_redirect_unit;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 10;
    localparam int CNT_MOD      = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      pc;
    logic [11:0]      branoff;
    logic             jal;
    logic             jalr;
    logic [2:0]       funct3;
    logic [31:0]      rs1_mod;
    logic [31:0]      rs2_mod;
    logic             redir_valid;
    logic             redir_ready;
    logic [31:0]      redir_pc;
    logic             flush;
    logic             link_valid;
    logic [31:0]      link_data;
    logic             misalign;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_redirect_unit #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .branoff    (branoff),
        .jal        (jal),
        .jalr       (jalr),
        .funct3     (funct3),
        .rs1_mod    (rs1_mod),
        .rs2_mod    (rs2_mod),
        .redir_valid(redir_valid),
        .redir_ready(redir_ready),
        .redir_pc   (redir_pc),
        .flush      (flush),
        .link_valid (link_valid),
        .link_data  (link_data),
        .misalign   (misalign),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_branch = 0;
    int          exp_taken  = 0;
    logic [31:0] exp_link   = '0;
    bit          last_redir;
    logic [31:0] last_tgt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: what a control transfer does architecturally.
    function automatic void model(input logic [31:0] p, input logic [11:0] o,
                                  input logic j, input logic jr, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit tk, output logic [31:0] tgt);
        int sa, sb, so;
        sa = a;
        sb = b;
        if (j || jr) tk = 1;
        else begin
            case (f)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = (sa <  sb);
                3'd5:    tk = (sa >= sb);
                3'd6:    tk = (a <  b);
                3'd7:    tk = (a >= b);
                default: tk = 0;
            endcase
        end
        if (jr && !j) begin
            tgt = (p & 32'hFFFF_F000) | (32'(o) & 32'h0000_0FFE);
        end else begin
            so  = o[11] ? int'(o) - 4096 : int'(o);
            tgt = p + 32'(so);
        end
    endfunction

    // Present one instruction, check the RESOLVE cycle and the cycle after.
    // Returns at the start of the first cycle after RESOLVE.
    task automatic send(input logic [31:0] i_pc, input logic [11:0] i_off,
                        input logic i_jal, input logic i_jalr, input logic [2:0] i_f3,
                        input logic [31:0] i_rs1, input logic [31:0] i_rs2);
        bit          tk;
        bit          exp_mis;
        logic [31:0] tgt;
        int          waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_before_issue", in_ready, 1);
        pc = i_pc; branoff = i_off; jal = i_jal; jalr = i_jalr;
        funct3 = i_f3; rs1_mod = i_rs1; rs2_mod = i_rs2;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check("in_ready_resolve", in_ready, 0);
        check("redir_valid_resolve", redir_valid, 0);
        check("flush_resolve", flush, 0);
        check("link_valid_idle", link_valid, 0);
        check("misalign_idle", misalign, 0);

        model(i_pc, i_off, i_jal, i_jalr, i_f3, i_rs1, i_rs2, tk, tgt);
        exp_branch = (exp_branch + 1) % CNT_MOD;
        if (i_jal || i_jalr) exp_link = i_pc + 32'd4;
        last_redir = tk && !tgt[1];
        exp_mis    = tk && tgt[1];
        last_tgt   = tgt;
        if (last_redir) exp_taken = (exp_taken + 1) % CNT_MOD;

        @(posedge clk); #1;
        check("branch_cnt", 32'(branch_cnt), 32'(exp_branch));
        check("taken_cnt", 32'(taken_cnt), 32'(exp_taken));
        check("link_valid", link_valid, (i_jal || i_jalr));
        check("link_data", link_data, exp_link);
        check("misalign", misalign, exp_mis);
        check("redir_valid", redir_valid, last_redir);
        check("in_ready_after_resolve", in_ready, !last_redir);
        check("flush_after_resolve", flush, 0);
        if (last_redir) check("redir_pc", redir_pc, tgt);
    endtask

    // Hold redir_ready low for 'delay' cycles (with ignored in_valid pulses),
    // then accept and follow the flush to its end.
    task automatic complete_redirect(input int delay);
        for (int i = 0; i < delay; i++) begin
            redir_ready = 0;
            in_valid = 1; jal = 1; pc = $urandom; branoff = 12'($urandom);
            check("redir_valid_hold", redir_valid, 1);
            check("redir_pc_hold", redir_pc, last_tgt);
            check("flush_before_accept", flush, 0);
            check("in_ready_redirect", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 0; jal = 0;
        redir_ready = 1;
        @(posedge clk); #1;
        redir_ready = 0;
        check("redir_valid_after_accept", redir_valid, 0);
        check("flush_first", flush, 1);
        check("in_ready_flush", in_ready, 0);
        for (int k = 1; k < FLUSH_CYCLES; k++) begin
            @(posedge clk); #1;
            check("flush_held", flush, 1);
            check("in_ready_flush_held", in_ready, 0);
        end
        @(posedge clk); #1;
        check("flush_end", flush, 0);
        check("in_ready_flush_end", in_ready, 1);
        check("branch_cnt_after_flush", 32'(branch_cnt), 32'(exp_branch));
    endtask

    // Assert reset between clock edges; outputs must clear without an edge.
    task automatic do_reset();
        rst = 1;
        #1;
        check("rst_redir_valid", redir_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_branch_cnt", 32'(branch_cnt), 0);
        check("rst_taken_cnt", 32'(taken_cnt), 0);
        check("rst_link_data", link_data, 0);
        check("rst_redir_pc", redir_pc, 0);
        exp_branch = 0; exp_taken = 0; exp_link = '0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r_pc, r_a, r_b;
        logic [2:0]  r_f3;
        logic        r_j, r_jr;

        rst = 1; in_valid = 0; pc = '0; branoff = '0; jal = 0; jalr = 0;
        funct3 = '0; rs1_mod = '0; rs2_mod = '0; redir_ready = 0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_redir_valid", redir_valid, 0);
        check("reset_redir_pc", redir_pc, 0);
        check("reset_flush", flush, 0);
        check("reset_link_valid", link_valid, 0);
        check("reset_link_data", link_data, 0);
        check("reset_misalign", misalign, 0);
        check("reset_branch_cnt", 32'(branch_cnt), 0);
        check("reset_taken_cnt", 32'(taken_cnt), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // BEQ taken, fetch ready immediately
        send(32'h100, 12'h010, 0, 0, 3'b000, 32'd5, 32'd5);
        check("beq_redir_pc", redir_pc, 32'h110);
        complete_redirect(0);

        // BLT signed taken, backward target
        send(32'h200, 12'hFF0, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1);
        check("blt_redir_pc", redir_pc, 32'h1F0);
        complete_redirect(0);

        // BLTU with the same operands: not taken
        send(32'h200, 12'hFF0, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1);
        check("bltu_not_taken", redir_valid, 0);

        // JALR to 0x3122: bit1 set, misaligned, link still produced
        send(32'h0000_3004, 12'h123, 0, 1, 3'b000, 32'd0, 32'd0);
        check("jalr_link_data", link_data, 32'h3008);

        // JALR aligned target
        send(32'h0000_3004, 12'h125, 0, 1, 3'b000, 32'd0, 32'd0);
        check("jalr_redir_pc", redir_pc, 32'h3124);
        complete_redirect(1);

        // JAL with fetch stalled for 5 cycles
        send(32'h40, 12'h020, 1, 0, 3'b000, 32'd0, 32'd0);
        complete_redirect(5);

        // BNE to 0x12: misaligned
        send(32'h10, 12'h002, 0, 0, 3'b001, 32'd1, 32'd2);

        // jal and jalr both set: jal form of target wins
        send(32'h1010, 12'h008, 1, 1, 3'b000, 32'd0, 32'd0);
        check("jal_priority_pc", redir_pc, 32'h1018);
        complete_redirect(0);

        // Unlisted funct3 with equal operands: not taken
        send(32'h500, 12'h040, 0, 0, 3'b010, 32'd7, 32'd7);

        // Reset during REDIRECT
        send(32'h40, 12'h020, 1, 0, 3'b000, 32'd0, 32'd0);
        @(posedge clk); #1;
        do_reset();

        // Reset during FLUSH
        send(32'h100, 12'h010, 0, 0, 3'b000, 32'd9, 32'd9);
        redir_ready = 1;
        @(posedge clk); #1;
        redir_ready = 0;
        check("flush_before_rst", flush, 1);
        do_reset();

        // Randomized instructions against the model
        for (int n = 0; n < 200; n++) begin
            r_pc = $urandom;
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = r_a;
                1:       r_b = ~r_a;
                default: r_b = $urandom;
            endcase
            r_f3 = 3'($urandom);
            r_j  = ($urandom_range(0, 7) == 0);
            r_jr = ($urandom_range(0, 7) == 0);
            send(r_pc, 12'($urandom), r_j, r_jr, r_f3, r_a, r_b);
            if (last_redir) complete_redirect($urandom_range(0, 3));
        end

        // Counter wrap: 2^CNT_W not-taken transfers from reset
        do_reset();
        for (int n = 0; n < CNT_MOD; n++) begin
            send($urandom, 12'($urandom), 0, 0, 3'b011, $urandom, $urandom);
        end
        check("branch_cnt_wrapped", 32'(branch_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
